// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM states and load-lane extraction for dmem_banked.
package dmem_pkg;
   localparam logic [2:0] SZ_B = 3'd1;
   localparam logic [2:0] SZ_H = 3'd2;
   localparam logic [2:0] SZ_W = 3'd4;
   typedef enum logic {CLEAR, IDLE} state_e;
   // Right-justify the addressed lanes of a read word, then sign- or zero-extend.
   function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] size, input logic sign);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      return size == SZ_B ? {{24{sign & sh[7]}}, sh[7:0]}
           : size == SZ_H ? {{16{sign & sh[15]}}, sh[15:0]}
           : word;
   endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one byte lane, DEPTH x 8-bit RAM with synchronous read.
//   clk   : clock
//   we    : write enable for mem[idx]
//   idx   : word index, shared by read and write
//   wdata : byte to write
//   rdata : registered read of mem[idx]
module dmem_bank #(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata
);
   logic [7:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
   end
endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: four-lane banked data memory with valid/ready requests, registered response,
// byte/half/word access with extension, fault reporting and a post-reset clear sequence.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_ready: request handshake
//   req_we, req_addr, req_wdata, req_size, req_sign : request fields
//   resp_valid, resp_rdata, resp_err : response, one cycle after each handshake
//   busy               : clear sequence running
module dmem_banked
   import dmem_pkg::*;
#(
   parameter int ADDR_W       = 11,
   parameter int DEPTH_WORDS  = 256,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [2:0]        req_size,
   input  logic              req_sign,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy
);
   localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W:0] BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);

   state_e        state_q, state_d;
   logic [IW-1:0] clr_cnt_q, clr_cnt_d;
   logic          resp_valid_q, resp_err_q, ld_q, sign_q;
   logic [1:0]    off_q;
   logic [2:0]    size_q;
   logic          clr, hs, err;
   logic [1:0]    off;
   logic [3:0]    be;
   logic [31:0]   wsh, rword;
   logic [IW-1:0] idx;

   assign clr        = state_q == CLEAR;
   assign busy       = clr;
   assign req_ready  = state_q == IDLE;
   assign hs         = req_valid & req_ready;
   assign off        = req_addr[1:0];
   assign idx        = clr ? clr_cnt_q : req_addr[IW+1:2];

   // Range check is done one bit wider so addr + size cannot wrap.
   assign err = !(req_size inside {SZ_B, SZ_H, SZ_W})
             || (req_size == SZ_H && off[0])
             || (req_size == SZ_W && off != 2'd0)
             || ({1'b0, req_addr} + (ADDR_W+1)'(req_size) > BYTES);

   assign be  = req_size == SZ_B ? 4'b0001 << off
              : req_size == SZ_H ? (off[1] ? 4'b1100 : 4'b0011)
              : 4'b1111;
   // Shifting the LSB-aligned store data up by the byte offset lands byte (k - off) on lane k.
   assign wsh = req_wdata << {off, 3'b000};

   for (genvar k = 0; k < 4; k++) begin : g_bank
      dmem_bank #(.DEPTH(DEPTH_WORDS), .IDX_W(IW)) u_bank (
         .clk   (clk),
         .we    (!rst && (clr || (hs && req_we && !err && be[k]))),
         .idx   (idx),
         .wdata (clr ? 8'h00 : wsh[8*k +: 8]),
         .rdata (rword[8*k +: 8])
      );
   end

   always_comb begin
      state_d   = (clr && clr_cnt_q != IW'(DEPTH_WORDS - 1)) ? CLEAR : IDLE;
      clr_cnt_d = clr ? clr_cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CLEAR_ON_RST ? CLEAR : IDLE;
         clr_cnt_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         ld_q         <= 1'b0;
         off_q        <= 2'd0;
         size_q       <= 3'd0;
         sign_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         resp_valid_q <= hs;
         resp_err_q   <= hs & err;
         ld_q         <= hs & !req_we & !err;
         off_q        <= off;
         size_q       <= req_size;
         sign_q       <= req_sign;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = ld_q ? lane_extend(rword, off_q, size_q, sign_q) : 32'h0;
endmodule
